// File: rtl/fft_frame_driver_if.sv
// Stream and FFT-core handshake bundle for fft_frame_driver.
// master = the frame driver; slave = its surroundings (source, sink, core).
interface fft_frame_driver_if #(
   parameter int DATA_W = 64
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              start;
   logic              done;
   logic [DATA_W-1:0] d0, d1, d2, d3;
   logic [DATA_W-1:0] q0, q1, q2, q3;

   modport master (
      input  s_valid, s_data, m_ready, done, q0, q1, q2, q3,
      output s_ready, m_valid, m_data, m_last, start, d0, d1, d2, d3
   );

   modport slave (
      output s_valid, s_data, m_ready, done, q0, q1, q2, q3,
      input  s_ready, m_valid, m_data, m_last, start, d0, d1, d2, d3
   );
endinterface

// File: rtl/fft_frame_driver.sv
// Host-side frame driver for a 4-lane FFT core: buffers one input frame,
// feeds it to the core as load beats, captures the result beats and replays them.
module fft_frame_driver #(
   parameter int N_POINTS = 256,
   parameter int DATA_W   = 64
) (
   input  logic                clk_i,
   input  logic                rst_i,
   fft_frame_driver_if.master  bus,
   output logic                busy_o,
   output logic                err_seq_o,
   output logic [15:0]         frame_cnt_o
);
   localparam int BEATS  = N_POINTS / 4;
   localparam int IDX_W  = $clog2(N_POINTS);
   localparam int BEAT_W = IDX_W - 2;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_POINTS - 1);
   localparam logic [BEAT_W:0]   BEATS_C   = (BEAT_W + 1)'(BEATS);
   localparam logic [BEAT_W:0]   LAST_BEAT = (BEAT_W + 1)'(BEATS - 1);

   typedef enum logic [2:0] {FILL, KICK, LOAD, WAIT, CAPT, DRAIN} state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  fill_q;
   logic [IDX_W-1:0]  j_q;
   logic [IDX_W-1:0]  j_d;
   logic [BEAT_W:0]   beat_q;
   logic [BEAT_W-1:0] beat_idx;
   logic              start_q;
   logic              m_valid_q;
   logic              err_q;
   logic [15:0]       frame_q;
   logic              s_fire;
   logic              m_fire;
   logic              load_rd;

   logic [DATA_W-1:0] q_lane  [4];
   logic [DATA_W-1:0] d_lane  [4];
   logic [DATA_W-1:0] rd_lane [4];

   assign beat_idx = beat_q[BEAT_W-1:0];
   assign s_fire   = (state_q == FILL) && bus.s_valid;
   assign m_fire   = m_valid_q && bus.m_ready;
   assign load_rd  = (state_q == KICK) || ((state_q == LOAD) && (beat_q != BEATS_C));

   assign q_lane[0] = bus.q0;
   assign q_lane[1] = bus.q1;
   assign q_lane[2] = bus.q2;
   assign q_lane[3] = bus.q3;

   // Drain read address runs one word ahead so M_DATA is ready on the cycle after a handshake.
   always_comb begin
      j_d = j_q;
      if (state_q == CAPT)
         j_d = '0;
      else if ((state_q == DRAIN) && m_fire && (j_q != LAST_IDX))
         j_d = j_q + 1'b1;
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [DATA_W-1:0] in_mem  [BEATS];
      logic [DATA_W-1:0] out_mem [BEATS];
      logic [DATA_W-1:0] d_q;
      logic [DATA_W-1:0] rd_q;

      always_ff @(posedge clk_i) begin
         if (s_fire && (fill_q[1:0] == 2'(gi)))
            in_mem[fill_q[IDX_W-1:2]] <= bus.s_data;
      end

      always_ff @(posedge clk_i) begin
         if (state_q == CAPT)
            out_mem[beat_idx] <= q_lane[gi];
      end

      always_ff @(posedge clk_i) begin
         rd_q <= out_mem[j_d[IDX_W-1:2]];
      end

      always_ff @(posedge clk_i) begin
         if (rst_i)
            d_q <= '0;
         else if (load_rd)
            d_q <= in_mem[beat_idx];
         else
            d_q <= '0;
      end

      assign d_lane[gi]  = d_q;
      assign rd_lane[gi] = rd_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= FILL;
         fill_q    <= '0;
         j_q       <= '0;
         beat_q    <= '0;
         start_q   <= 1'b0;
         m_valid_q <= 1'b0;
         err_q     <= 1'b0;
         frame_q   <= '0;
      end else begin
         start_q <= 1'b0;
         j_q     <= j_d;
         if (bus.done && (state_q != WAIT))
            err_q <= 1'b1;
         case (state_q)
            FILL: begin
               if (s_fire) begin
                  if (fill_q == LAST_IDX) begin
                     fill_q  <= '0;
                     start_q <= 1'b1;
                     state_q <= KICK;
                  end else begin
                     fill_q <= fill_q + 1'b1;
                  end
               end
            end
            KICK: begin
               beat_q  <= (BEAT_W + 1)'(1);
               state_q <= LOAD;
            end
            LOAD: begin
               if (beat_q == BEATS_C) begin
                  beat_q  <= '0;
                  state_q <= WAIT;
               end else begin
                  beat_q <= beat_q + 1'b1;
               end
            end
            WAIT: begin
               if (bus.done) begin
                  beat_q  <= '0;
                  state_q <= CAPT;
               end
            end
            CAPT: begin
               if (beat_q == LAST_BEAT) begin
                  beat_q    <= '0;
                  m_valid_q <= 1'b1;
                  state_q   <= DRAIN;
               end else begin
                  beat_q <= beat_q + 1'b1;
               end
            end
            DRAIN: begin
               if (m_fire && (j_q == LAST_IDX)) begin
                  m_valid_q <= 1'b0;
                  frame_q   <= frame_q + 16'd1;
                  state_q   <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   // Outputs are forced low combinationally so they read 0 for the whole reset cycle.
   assign bus.s_ready = !rst_i && (state_q == FILL);
   assign bus.start   = !rst_i && start_q;
   assign bus.d0      = rst_i ? '0 : d_lane[0];
   assign bus.d1      = rst_i ? '0 : d_lane[1];
   assign bus.d2      = rst_i ? '0 : d_lane[2];
   assign bus.d3      = rst_i ? '0 : d_lane[3];
   assign bus.m_valid = !rst_i && m_valid_q;
   assign bus.m_data  = (!rst_i && m_valid_q) ? rd_lane[j_q[1:0]] : '0;
   assign bus.m_last  = !rst_i && m_valid_q && (j_q == LAST_IDX);
   assign busy_o      = !rst_i && (state_q != FILL);
   assign err_seq_o   = !rst_i && err_q;
   assign frame_cnt_o = rst_i ? 16'd0 : frame_q;
endmodule

// File: tb/tb_fft_frame_driver.sv
// Scoreboard bench for fft_frame_driver with N_POINTS=16 and a simple core model.
module tb_fft_frame_driver;
   localparam int N  = 16;
   localparam int DW = 64;

   logic        clk;
   logic        rst;
   logic        busy;
   logic        err;
   logic [15:0] frame_cnt;

   fft_frame_driver_if #(.DATA_W(DW)) bus ();

   fft_frame_driver #(.N_POINTS(N), .DATA_W(DW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus),
      .busy_o      (busy),
      .err_seq_o   (err),
      .frame_cnt_o (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] d_exp [$];
   logic [64:0] m_exp [$];
   int          exp_frames = 0;
   bit          exp_err = 1'b0;
   bit          mr_toggle = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Monitor: load beats, output handshakes, hold stability, post-frame S_READY.
   int          load_pend = 0;
   bit          hold_pend = 1'b0;
   logic [63:0] hold_data;
   logic        hold_last;
   bit          last_hs = 1'b0;

   always @(negedge clk) begin
      logic [63:0] e;
      logic [64:0] me;
      if (rst) begin
         d_exp.delete();
         m_exp.delete();
         load_pend = 0;
         hold_pend = 1'b0;
         last_hs   = 1'b0;
      end else begin
         if (load_pend > 0) begin
            e = (d_exp.size() > 0) ? d_exp.pop_front() : 64'hBAD0; check("d0_beat", bus.d0, e);
            e = (d_exp.size() > 0) ? d_exp.pop_front() : 64'hBAD1; check("d1_beat", bus.d1, e);
            e = (d_exp.size() > 0) ? d_exp.pop_front() : 64'hBAD2; check("d2_beat", bus.d2, e);
            e = (d_exp.size() > 0) ? d_exp.pop_front() : 64'hBAD3; check("d3_beat", bus.d3, e);
            check("load_sready", 64'(bus.s_ready), 64'd0);
            check("load_busy", 64'(busy), 64'd1);
            load_pend--;
         end else begin
            check("d_idle", bus.d0 | bus.d1 | bus.d2 | bus.d3, 64'd0);
         end
         if (bus.start) load_pend = 4;

         if (last_hs) begin
            check("sready_after_last", 64'(bus.s_ready), 64'd1);
            check("mvalid_after_last", 64'(bus.m_valid), 64'd0);
            last_hs = 1'b0;
         end

         if (bus.m_valid) begin
            if (hold_pend) begin
               check("m_hold_data", bus.m_data, hold_data);
               check("m_hold_last", 64'(bus.m_last), 64'(hold_last));
            end
            if (bus.m_ready) begin
               hold_pend = 1'b0;
               me = (m_exp.size() > 0) ? m_exp.pop_front() : {1'b0, 64'hDEAD};
               check("m_data", bus.m_data, me[63:0]);
               check("m_last", 64'(bus.m_last), 64'(me[64]));
               if (bus.m_last) last_hs = 1'b1;
            end else begin
               hold_pend = 1'b1;
               hold_data = bus.m_data;
               hold_last = bus.m_last;
            end
         end else begin
            hold_pend = 1'b0;
         end
      end
   end

   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (mr_toggle) bus.m_ready = ~bus.m_ready;
         else           bus.m_ready = 1'b1;
      end
   end

   // Sends samples lo..hi; each accepted sample is pushed as an expected load lane word.
   task automatic send(input int lo, input int hi, input bit gappy);
      bit acc;
      for (int i = lo; i <= hi; i++) begin
         if (gappy && ($urandom_range(1) == 0)) begin
            bus.s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         bus.s_data  = 64'(i);
         bus.s_valid = 1'b1;
         acc = 1'b0;
         for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            if (bus.s_ready) begin
               acc = 1'b1;
               d_exp.push_back(64'(i));
            end
            @(posedge clk);
            #1;
         end
         if (!acc) check("s_accept_timeout", 64'd0, 64'd1);
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic run_frame(input bit gappy, input bit toggle, input logic [63:0] base,
                            input bit inject_err);
      int  cnt;
      bit  fin;
      mr_toggle = toggle;
      if (inject_err) begin
         send(0, 4, gappy);
         bus.done = 1'b1;
         @(posedge clk);
         #1;
         bus.done = 1'b0;
         exp_err  = 1'b1;
         @(negedge clk);
         check("err_set", 64'(err), 64'd1);
         @(posedge clk);
         #1;
         send(5, N - 1, gappy);
      end else begin
         send(0, N - 1, gappy);
      end
      @(negedge clk);
      check("start_pulse", 64'(bus.start), 64'd1);
      check("frame_cnt_pre", 64'(frame_cnt), 64'(exp_frames));
      @(negedge clk);
      check("start_single", 64'(bus.start), 64'd0);
      @(posedge clk);
      #1;
      repeat (18) @(posedge clk);
      #1;
      bus.done = 1'b1;
      @(posedge clk);
      #1;
      bus.done = 1'b0;
      for (int k = 0; k < N / 4; k++) begin
         bus.q0 = base + 64'(4 * k);
         bus.q1 = base + 64'(4 * k + 1);
         bus.q2 = base + 64'(4 * k + 2);
         bus.q3 = base + 64'(4 * k + 3);
         for (int l = 0; l < 4; l++)
            m_exp.push_back({(4 * k + l) == N - 1, base + 64'(4 * k + l)});
         @(posedge clk);
         #1;
      end
      bus.q0 = '0; bus.q1 = '0; bus.q2 = '0; bus.q3 = '0;
      @(negedge clk);
      check("m_valid_rise", 64'(bus.m_valid), 64'd1);
      cnt = 1;
      fin = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
         @(negedge clk);
         if (bus.m_valid) cnt++;
         else if (m_exp.size() == 0) fin = 1'b1;
      end
      if (!fin) check("drain_timeout", 64'd0, 64'd1);
      if (!toggle) check("drain_len", 64'(cnt), 64'(N));
      exp_frames++;
      check("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
      check("err_sticky", 64'(err), 64'(exp_err));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.done = 1'b0;
      bus.q0 = '0; bus.q1 = '0; bus.q2 = '0; bus.q3 = '0;
      @(negedge clk);
      check("rst_ctl", 64'({bus.s_ready, bus.start, bus.m_valid, bus.m_last, busy, err}), 64'd0);
      check("rst_d", bus.d0 | bus.d1 | bus.d2 | bus.d3, 64'd0);
      check("rst_cnt", 64'(frame_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("sready_after_rst", 64'(bus.s_ready), 64'd1);
      check("busy_after_rst", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      run_frame(1'b0, 1'b0, 64'h100, 1'b0);
      run_frame(1'b1, 1'b1, 64'h100, 1'b0);
      run_frame(1'b0, 1'b0, 64'h200, 1'b1);

      // Abort during load beat 2.
      send(0, N - 1, 1'b0);
      @(negedge clk);
      check("start_pulse_abort", 64'(bus.start), 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ctl", 64'({bus.s_ready, bus.start, bus.m_valid, bus.m_last, busy, err}), 64'd0);
      check("rst_mid_d", bus.d0 | bus.d1 | bus.d2 | bus.d3, 64'd0);
      check("rst_mid_cnt", 64'(frame_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_frames = 0;
      exp_err    = 1'b0;
      @(negedge clk);
      check("sready_after_abort", 64'(bus.s_ready), 64'd1);
      check("frame_cnt_abort", 64'(frame_cnt), 64'd0);
      @(posedge clk);
      #1;

      run_frame(1'b0, 1'b0, 64'h300, 1'b0);
      run_frame(1'b1, 1'b0, 64'h400, 1'b0);
      check("frame_cnt_two", 64'(frame_cnt), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/fft_frame_driver.md
Name: fft_frame_driver

Overview:
- Host-side counterpart of the 4-lane FFT core top: drives the core's START/D0..D3 load interface and consumes its DONE/Q0..Q3 result interface.
- Converts a one-sample-per-cycle ready/valid input stream into 4-lane load beats, and captures the core's burst of result beats.
- Replays the captured results as a one-sample-per-cycle ready/valid output stream.
- One frame in flight at a time; full-frame input and output buffers decouple stream backpressure from the core's fixed-rate beats.

Parameters:
- N_POINTS, 256, FFT frame length in complex samples; multiple of 4, ≥ 8.
- DATA_W, 64, complex sample width, {re[31:0], im[31:0]}; passed through unmodified.
- BEATS, N_POINTS/4, derived (localparam): core beats per frame.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- S_VALID  in  1  input sample valid
- S_READY  out  1  driver accepts input sample
- S_DATA  in  DATA_W  input sample, natural order
- M_VALID  out  1  output sample valid
- M_READY  in  1  downstream accepts output sample
- M_DATA  out  DATA_W  output sample
- M_LAST  out  1  marks final sample of frame
- START  out  1  one-cycle start pulse to core
- DONE  in  1  one-cycle completion pulse from core
- D0..D3  out  DATA_W each  core load lanes
- Q0..Q3  in  DATA_W each  core result lanes
- BUSY  out  1  high in any state other than FILL
- ERR_SEQ  out  1  sticky: DONE seen outside WAIT
- FRAME_CNT  out  16  completed frames, wraps at 65535→0

Behaviour:
- Reset: the only reset is synchronous RST. While RST is high, all outputs are 0 (including S_READY, START, D0..D3, M_*, ERR_SEQ, FRAME_CNT) and all counters clear.
- State after reset is FILL, so S_READY=1 in the first cycle after RST falls. Buffer contents are not cleared.
- RST mid-frame aborts immediately: any partial input, in-flight core operation and undrained output are discarded. DONE arriving after an abort while in FILL sets ERR_SEQ.
- Input and output transfers happen on cycles with VALID&READY high at the rising edge.
- FILL:
  - S_READY=1.
  - Accepted sample i (0..N_POINTS-1) is written to in_buf beat i/4, lane i%4 (lane0→D0).
  - Acceptance of sample N_POINTS-1 moves the state to KICK; S_READY drops the next cycle.
- KICK: START=1 for exactly one cycle, then the state moves to LOAD.
- LOAD:
  - D0..D3 are registered outputs carrying beat k in the (k+1)-th cycle after the START cycle, k=0..BEATS-1, back-to-back with no gaps.
  - D0..D3 return to 0 after the last beat.
  - The state moves to WAIT.
- WAIT:
  - Idle until DONE=1.
  - Q0..Q3 carry result beat k in the (k+1)-th cycle after the DONE cycle.
  - DONE moves the state to CAPT.
- CAPT: capture BEATS consecutive cycles of Q0..Q3 into out_buf with no gaps and no stalls, then move to DRAIN.
- DRAIN:
  - Output word j (0..N_POINTS-1) is out_buf beat j/4, lane j%4.
  - M_VALID=1 and M_DATA, M_LAST stay stable until the handshake; M_LAST=1 only for j=N_POINTS-1.
  - M_VALID rises in the cycle after the last capture cycle.
  - After the final handshake: M_VALID=0 the next cycle, FRAME_CNT increments, and the state returns to FILL (S_READY=1 in that same next cycle).
- DONE in any state other than WAIT is ignored for sequencing and sets ERR_SEQ, which stays set until RST.
- START is never asserted outside KICK. BUSY = (state != FILL).
- Minimum frame turnaround = N_POINTS fill + 1 + BEATS + core latency + BEATS + N_POINTS drain cycles.

Test Plan:
- N_POINTS=16. Stream samples 0x0..0xF with S_VALID held high → START pulses exactly 1 cycle after sample 15 is accepted. Next 4 cycles: D0..D3 = {0,1,2,3}, {4,5,6,7}, {8,9,10,11}, {12,13,14,15}; S_READY=0 and BUSY=1 throughout.
- Core model pulses DONE 20 cycles after START, then Q beats {0x100+4k .. 0x103+4k}, k=0..3. With M_READY=1: M_DATA = 0x100..0x10F on 16 consecutive cycles, M_LAST only on 0x10F, FRAME_CNT=1.
- Random S_VALID gaps (50%) and M_READY toggling every other cycle → identical D beats and M sequence as above. M_DATA/M_LAST hold stable while M_VALID=1 and M_READY=0.
- DONE pulsed during FILL (after 5 samples accepted) → ERR_SEQ=1 the next cycle and remains 1. Fill and LOAD proceed normally (16 samples, one START).
- RST asserted for 1 cycle during LOAD beat 2 → all outputs 0 in the reset cycle, S_READY=1 the next cycle. A new 16-sample frame produces a correct START/D sequence and FRAME_CNT stays 0.
- Two full frames back-to-back → FRAME_CNT=2. S_READY rises the cycle after the first frame's M_LAST handshake.
